// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter and its companion detectors:
// FSM state encoding and default geometry.
package seq_pattern_tx_pkg;

  localparam int unsigned DEF_W  = 8;
  localparam int unsigned DEF_LW = 4;
  localparam int unsigned DEF_CW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_pattern_cfg.sv
// Combinational clamp of the requested frame configuration into a legal
// length, overlap skip and repetition count.
module seq_pattern_cfg
  import seq_pattern_tx_pkg::*;
#(
  parameter int unsigned W  = DEF_W,
  parameter int unsigned LW = DEF_LW,
  parameter int unsigned CW = DEF_CW
) (
  input  logic [LW-1:0] i_len,
  input  logic [LW-1:0] i_skip,
  input  logic [CW-1:0] i_repeat,
  output logic [LW-1:0] o_len,
  output logic [LW-1:0] o_skip,
  output logic [CW-1:0] o_repeat
);

  always_comb begin
    if (i_len == '0)
      o_len = LW'(1);
    else if (i_len > LW'(W))
      o_len = LW'(W);
    else
      o_len = i_len;

    // Skip is bounded by the already-clamped length so a repeat always sends >= 1 bit.
    o_skip   = (i_skip >= o_len) ? o_len - LW'(1) : i_skip;
    o_repeat = (i_repeat == '0) ? CW'(1) : i_repeat;
  end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: sends a latched pattern MSB-first, optionally
// repeated with leading-bit overlap and idle gaps between repetitions.
module seq_pattern_tx
  import seq_pattern_tx_pkg::*;
#(
  parameter int unsigned W  = DEF_W,
  parameter int unsigned LW = DEF_LW,
  parameter int unsigned CW = DEF_CW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [W-1:0]  i_pattern,
  input  logic [LW-1:0] i_len,
  input  logic [LW-1:0] i_skip,
  input  logic [CW-1:0] i_repeat,
  input  logic [CW-1:0] i_gap,
  output logic          o_x,
  output logic          o_x_valid,
  output logic          o_busy,
  output logic          o_done
);

  state_t        state_q, state_d;
  logic [W-1:0]  pat_q, pat_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] skip_q, skip_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [CW-1:0] rep_q, rep_d;
  logic [CW-1:0] gap_q, gap_d;
  logic [CW-1:0] gap_cnt_q, gap_cnt_d;
  logic          x_d, valid_d, busy_d, done_d;

  logic [LW-1:0] cfg_len, cfg_skip;
  logic [CW-1:0] cfg_rep;
  logic [LW-1:0] rep_idx;

  seq_pattern_cfg #(.W(W), .LW(LW), .CW(CW)) u_cfg (
    .i_len    (i_len),
    .i_skip   (i_skip),
    .i_repeat (i_repeat),
    .o_len    (cfg_len),
    .o_skip   (cfg_skip),
    .o_repeat (cfg_rep)
  );

  // First bit index of repetitions 2..N.
  assign rep_idx = len_q - skip_q - LW'(1);

  function automatic logic bit_at(input logic [W-1:0] p, input logic [LW-1:0] i);
    logic [W-1:0] s;
    s = p >> i;
    return s[0];
  endfunction

  // Outputs are computed for the state being entered and registered with it,
  // so the first bit is visible in the cycle right after the start edge.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    skip_d    = skip_q;
    idx_d     = idx_q;
    rep_d     = rep_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    x_d       = 1'b0;
    valid_d   = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = SEND;
          pat_d   = i_pattern;
          len_d   = cfg_len;
          skip_d  = cfg_skip;
          rep_d   = cfg_rep;
          gap_d   = i_gap;
          idx_d   = cfg_len - LW'(1);
          x_d     = bit_at(i_pattern, cfg_len - LW'(1));
          valid_d = 1'b1;
        end
      end
      SEND: begin
        if (idx_q != '0) begin
          idx_d   = idx_q - LW'(1);
          x_d     = bit_at(pat_q, idx_q - LW'(1));
          valid_d = 1'b1;
        end else if (rep_q <= CW'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          rep_d = rep_q - CW'(1);
          if (gap_q == '0) begin
            idx_d   = rep_idx;
            x_d     = bit_at(pat_q, rep_idx);
            valid_d = 1'b1;
          end else begin
            state_d   = GAP;
            gap_cnt_d = gap_q;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q > CW'(1)) begin
          gap_cnt_d = gap_cnt_q - CW'(1);
        end else begin
          gap_cnt_d = '0;
          state_d   = SEND;
          idx_d     = rep_idx;
          x_d       = bit_at(pat_q, rep_idx);
          valid_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      skip_q    <= '0;
      idx_q     <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      o_x       <= 1'b0;
      o_x_valid <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      skip_q    <= skip_d;
      idx_q     <= idx_d;
      rep_q     <= rep_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      o_x       <= x_d;
      o_x_valid <= valid_d;
      o_busy    <= busy_d;
      o_done    <= done_d;
    end
  end

endmodule
